// File: rtl/btn_debounce.sv
// btn_debounce: debounces N_BTN push-buttons on ticks from the rising edges of slow_clk
module btn_debounce #(
  parameter int N_BTN          = 5,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             sample_tick
);
  localparam logic [3:0] LAST = 4'(STABLE_SAMPLES - 1);
  logic             s1_q, s2_q, s3_q, tick_q;
  logic [N_BTN-1:0] b1_q, b2_q, level_q, level_d, pulse_q;
  logic [3:0]       cnt_q [N_BTN];
  logic [3:0]       cnt_d [N_BTN];
  // a sample that agrees with the level restarts the count; the LAST disagreeing one flips the level
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++)
      if (tick_q) begin
        cnt_d[i]   = (b2_q[i] == level_q[i] || cnt_q[i] == LAST) ? 4'd0 : cnt_q[i] + 4'd1;
        level_d[i] = (b2_q[i] != level_q[i] && cnt_q[i] == LAST) ? b2_q[i] : level_q[i];
      end
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      tick_q  <= 1'b0;
      b1_q    <= '0;
      b2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      s1_q    <= slow_clk;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      tick_q  <= s2_q & ~s3_q;
      b1_q    <= btn_raw;
      b2_q    <= b1_q;
      level_q <= level_d;
      pulse_q <= level_d & ~level_q;
      cnt_q   <= cnt_d;
    end
  end
  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign sample_tick = tick_q;
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed table, corner sequences and random stimulus against a sample-history model
module tb_btn_debounce;
  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       slow_clk;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_pulse;
  logic       sample_tick;
  int         total = 0, bad = 0;

  btn_debounce #(.N_BTN(5), .STABLE_SAMPLES(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .sample_tick(sample_tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: inputs recorded per clock edge; a value sampled at edge x is visible
  // only if no reset happened at or after x.
  logic       sl [16];
  logic [4:0] rw [16];
  int         e = 0, last_rst = 0;
  bit         seen = 0;
  logic       m_tick = 1'b0;
  logic [4:0] m_lvl = '0, m_pulse = '0, mv;
  int         run [5];

  function automatic logic age_s(input int x);
    return (x > last_rst) ? sl[x & 15] : 1'b0;
  endfunction
  function automatic logic [4:0] age_r(input int x);
    return (x > last_rst) ? rw[x & 15] : 5'd0;
  endfunction

  always @(posedge clk_in) begin
    sl[e & 15] = slow_clk;
    rw[e & 15] = btn_raw;
    if (!rst_n) begin
      last_rst = e;
      seen     = 1;
      m_tick   = 1'b0;
      m_lvl    = '0;
      m_pulse  = '0;
      for (int i = 0; i < 5; i++) run[i] = 0;
    end else begin
      m_pulse = '0;
      if (m_tick) begin
        mv = age_r(e - 2);
        for (int i = 0; i < 5; i++) begin
          run[i] = (mv[i] == m_lvl[i]) ? 0 : run[i] + 1;
          if (run[i] == 4) begin
            m_pulse[i] = mv[i];
            m_lvl[i]   = mv[i];
            run[i]     = 0;
          end
        end
      end
      m_tick = age_s(e - 2) & ~age_s(e - 3);
    end
    e++;
  end

  always @(negedge clk_in)
    if (seen) begin
      chk("model_tick", 32'(sample_tick), 32'(m_tick));
      chk("model_level", 32'(btn_level), 32'(m_lvl));
      chk("model_pulse", 32'(btn_pulse), 32'(m_pulse));
    end

  // one slow_clk period: high for 10 edges, low for 10 edges
  task automatic run_vec(input logic [4:0] r, input logic [4:0] exp_lvl, input logic [4:0] exp_pm);
    int nt = 0, ti = -1, npc = 0;
    logic [4:0] pm = '0;
    btn_raw  = r;
    slow_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (sample_tick) begin
        nt++;
        if (ti < 0) ti = i;
      end
      pm |= btn_pulse;
      if (btn_pulse != 0) npc++;
      if (i == 9) slow_clk = 1'b0;
    end
    chk("tick_count", 32'(nt), 32'd1);
    chk("tick_pos", 32'(ti), 32'd2);
    chk("vec_level", 32'(btn_level), 32'(exp_lvl));
    chk("vec_pulse_mask", 32'(pm), 32'(exp_pm));
    chk("vec_pulse_cycles", 32'(npc), (exp_pm != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset(input logic [4:0] r);
    rst_n    = 1'b0;
    slow_clk = 1'b0;
    btn_raw  = r;
    repeat (2) begin
      @(negedge clk_in);
      chk("rst_outputs", {20'd0, btn_level, btn_pulse, 1'b0, sample_tick}, 32'd0);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] raw;
    logic [4:0] lvl;
    logic [4:0] pm;
  } vec_t;
  vec_t tbl [19];

  initial begin
    int hc = 5, nt = 0;
    tbl = '{
      '{5'h01, 5'h00, 5'h00}, '{5'h01, 5'h00, 5'h00}, '{5'h00, 5'h00, 5'h00},
      '{5'h01, 5'h00, 5'h00}, '{5'h01, 5'h00, 5'h00}, '{5'h01, 5'h00, 5'h00},
      '{5'h01, 5'h01, 5'h01},
      '{5'h05, 5'h01, 5'h00}, '{5'h05, 5'h01, 5'h00}, '{5'h05, 5'h01, 5'h00},
      '{5'h05, 5'h05, 5'h04},
      '{5'h01, 5'h05, 5'h00}, '{5'h01, 5'h05, 5'h00}, '{5'h01, 5'h05, 5'h00},
      '{5'h01, 5'h01, 5'h00},
      '{5'h0B, 5'h01, 5'h00}, '{5'h0B, 5'h01, 5'h00}, '{5'h0B, 5'h01, 5'h00},
      '{5'h0B, 5'h0B, 5'h0A}
    };
    // buttons held through reset register on the 4th tick
    do_reset(5'h1f);
    repeat (3) run_vec(5'h1f, 5'h00, 5'h00);
    run_vec(5'h1f, 5'h1f, 5'h1f);
    do_reset(5'h00);
    // bounce, release and simultaneous press
    for (int i = 0; i < 19; i++) run_vec(tbl[i].raw, tbl[i].lvl, tbl[i].pm);
    // mid-count reset, then static slow_clk freezes everything
    repeat (3) run_vec(5'h10, 5'h0B, 5'h00);
    do_reset(5'h10);
    repeat (50) begin
      @(negedge clk_in);
      if (sample_tick) nt++;
    end
    chk("frozen_ticks", 32'(nt), 32'd0);
    chk("frozen_level", 32'(btn_level), 32'd0);
    repeat (3) run_vec(5'h10, 5'h00, 5'h00);
    run_vec(5'h10, 5'h10, 5'h10);
    // random bouncing buttons, irregular slow_clk and occasional resets
    repeat (4000) begin
      @(negedge clk_in);
      if ($urandom_range(0, 29) == 0) btn_raw[$urandom_range(0, 4)] ^= 1'b1;
      hc--;
      if (hc == 0) begin
        slow_clk = ~slow_clk;
        hc = $urandom_range(2, 12);
      end
      rst_n = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1'b1;
    @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 5: number of push-button inputs.
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, legal range 2..15: consecutive disagreeing samples needed to change a debounced level.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port slow_clk, input, 1 bit: the clock-divider output, treated as data only and never used as a clock.
REQ-006 SHALL have port btn_raw, input, N_BTN bits: asynchronous, bouncing button levels, 1 = pressed.
REQ-007 SHALL have port btn_level, output, N_BTN bits: debounced, registered button levels.
REQ-008 SHALL have port btn_pulse, output, N_BTN bits: one-cycle press strobes.
REQ-009 SHALL have port sample_tick, output, 1 bit: registered one-cycle sample strobe.

Function
REQ-010 SHALL pass slow_clk through two synchronizer flops (s1, s2) plus one edge flop (s3).
REQ-011 SHALL register sample_tick as s2 AND NOT s3.
REQ-012 Tick timing: slow_clk first sampled high at edge k gives sample_tick high for exactly one clk_in cycle following edge k+2.
REQ-013 Falling edges of slow_clk SHALL NOT generate a tick.
REQ-014 SHALL synchronize each btn_raw bit through its own two-flop synchronizer before any use.
REQ-015 Per button: 4-bit counter cnt; on cycles without sample_tick, cnt and btn_level SHALL hold.
REQ-016 On sample_tick, if the synchronized bit equals btn_level[i], cnt[i] SHALL clear to 0.
REQ-017 On sample_tick, if the bits differ and cnt[i]+1 < STABLE_SAMPLES, cnt[i] SHALL increment.
REQ-018 On sample_tick, if the bits differ and cnt[i]+1 == STABLE_SAMPLES, btn_level[i] SHALL take the synchronized value and cnt[i] SHALL clear.
REQ-019 Any agreeing sample (bounce) SHALL restart the count; the level changes only after STABLE_SAMPLES consecutive disagreeing ticks.
REQ-020 btn_pulse[i] SHALL be high for exactly the one clk_in cycle in which btn_level[i] first reads 1 after a 0->1 transition; it is registered at the same edge as btn_level.
REQ-021 A 1->0 transition of btn_level SHALL NOT produce a pulse.
REQ-022 Buttons SHALL be fully independent; simultaneous transitions on several buttons SHALL pulse in the same cycle.
REQ-023 slow_clk held constant SHALL produce no ticks, and all levels SHALL remain frozen indefinitely.
REQ-024 A btn_raw change shorter than one tick period SHALL be invisible unless captured by a tick.

Reset
REQ-025 When rst_n is low at a clk_in edge, all synchronizer flops, s3, cnt, btn_level, btn_pulse and sample_tick SHALL become 0 at that edge.
REQ-026 Reset asserted mid-count SHALL discard the partial count; after release, a full STABLE_SAMPLES ticks are required.
REQ-027 A button held through reset SHALL register as a press (btn_level 0->1 with pulse) on the STABLE_SAMPLES-th tick after release.

Verification
REQ-028 Reset case: rst_n=0 for 2 cycles with btn_raw=5'b11111, then slow_clk toggling every 10 clk_in -> all outputs 0 during reset; btn_level=5'b11111 and btn_pulse=5'b11111 for one cycle on the 4th tick after release.
REQ-029 Tick timing: slow_clk toggling every 10 clk_in cycles -> sample_tick one cycle wide, period 20 cycles, high in the cycle after the 3rd clk_in edge following the slow_clk rise; none on the fall.
REQ-030 Bounce case: btn_raw[0] samples 1,1,0,1,1,1,1 on successive ticks -> btn_level[0] rises only at the 7th tick; exactly one btn_pulse[0].
REQ-031 Release case: btn_raw[2] held 1 until stable, then held 0 -> btn_level[2] falls on the 4th tick; btn_pulse[2] stays 0.
REQ-032 Simultaneous press: btn_raw[1] and btn_raw[3] rise together -> both levels and both pulses assert in the same cycle.
REQ-033 Mid-count reset: reset pulsed after 3 disagreeing ticks -> no level change; the press registers on the 4th tick after release, with slow_clk held static otherwise freezing all outputs.
